// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//
// Shared definitions for the fetch-stage PC unit of the 16-bit single-cycle
// core: default widths, reset PC, the sequencer state encoding, and a small
// helper that defines what a "consume" is on the decode handshake.
//
// Contents:
//   PC_W        program counter / instruction address width (6)
//   INSTR_W     instruction width (16)
//   RESET_PC    PC loaded on reset (6'd0)
//   BR_SAT      saturation value of the taken-branch counter (8'hFF)
//   fetch_state_e  ST_RST / ST_REQ / ST_HOLD / ST_HALTED, two-bit encoding
//   is_consume()   decode accepts the held instruction this cycle
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int              PC_W     = 6;
    localparam int              INSTR_W  = 16;
    localparam logic [PC_W-1:0] RESET_PC = 6'd0;
    localparam logic [7:0]      BR_SAT   = 8'hFF;

    typedef enum logic [1:0] {
        ST_RST    = 2'b00,
        ST_REQ    = 2'b01,
        ST_HOLD   = 2'b10,
        ST_HALTED = 2'b11
    } fetch_state_e;

    // A hazard stall overrides decode's ready: nothing is consumed while
    // stall is high, even if ready is also high.
    function automatic logic is_consume(input logic ready, input logic stall);
        return ready & ~stall;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_if
//
// Bundles the two handshakes of the fetch unit:
//   - instruction memory  : imem_req / imem_addr  ->  imem_ack / imem_rdata
//   - decode              : instr / instr_pc / instr_valid  ->  instr_ready,
//                           plus the decode-side controls stall and halt
//
// Modports:
//   master  the fetch unit (drives the request and the instruction to decode)
//   slave   the environment (instruction memory and decode stage)
// -----------------------------------------------------------------------------
interface fetch_pc_unit_if #(
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) ();

    // Instruction memory handshake
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    // Decode handshake
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               stall;
    logic               halt;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr, instr_pc, instr_valid,
        input  instr_ready, stall, halt
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr, instr_pc, instr_valid,
        output instr_ready, stall, halt
    );

endinterface

// File: rtl/sat_counter8.sv
// -----------------------------------------------------------------------------
// sat_counter8
//
// 8-bit saturating event counter. Counts up by one on each cycle with inc=1,
// sticks at 8'hFF, and clears only on reset.
//
// Only built when FETCH_BR_COUNT_EN is defined; without it the fetch unit ties
// its br_count port to zero and this module does not exist in the design.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous, active-low reset
//   inc    in   count one event this cycle
//   count  out  current count (8 bits)
// -----------------------------------------------------------------------------
`ifdef FETCH_BR_COUNT_EN
module sat_counter8
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != BR_SAT)) begin
            count_d = count_q + 8'd1;
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch and the
    // sensitivity list holds only the clock; state registers use <= so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Fetch-stage program counter and instruction-fetch sequencer. Holds the PC,
// exports PC+1 to the branch-select mux, fetches one instruction at a time
// from instruction memory (req/ack) and hands it to decode (valid/ready).
// Once decode consumes the instruction the mux-selected next PC is loaded and
// the next fetch starts. A consumed halt instruction parks the unit until
// reset.
//
// Sequencer:  RST -> REQ -> HOLD -> REQ ...   (HOLD -> HALTED on halt)
//   RST     one idle cycle after reset, no request
//   REQ     imem_req high, waiting for imem_ack
//   HOLD    instr_valid high, waiting for a consume (ready & ~stall)
//   HALTED  quiet; left only through reset
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous, active-low reset
//   next_pc   in   PC selected by the branch-select mux
//   br_taken  in   mux select (1 = branch target), sampled on a consume
//   pc_plus1  out  pc + 1, wrapping, combinational
//   halted    out  core halted
//   br_count  out  taken-branch count (zero unless FETCH_BR_COUNT_EN)
//   bus       fetch_pc_unit_if.master: imem and decode handshakes
//
// Build option:
//   FETCH_BR_COUNT_EN  defined   -> br_count is an 8-bit saturating count of
//                                   taken branches (non-halt consumes)
//                      undefined -> br_count is tied to 8'h00
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int              PC_W     = fetch_pkg::PC_W,
    parameter int              INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(fetch_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] next_pc,
    input  logic            br_taken,
    output logic [PC_W-1:0] pc_plus1,
    output logic            halted,
    output logic [7:0]      br_count,
    fetch_pc_unit_if.master bus
);

    import fetch_pkg::*;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    fetch_state_e       state_q,       state_d;
    logic [PC_W-1:0]    pc_q,          pc_d;
    logic               imem_req_q,    imem_req_d;
    logic [INSTR_W-1:0] instr_q,       instr_d;
    logic [PC_W-1:0]    instr_pc_q,    instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               halted_q,      halted_d;

    logic consume;
    logic br_inc;

    // Only an instruction actually held in HOLD can be consumed; ready/stall
    // in other states are irrelevant.
    assign consume = (state_q == ST_HOLD) && is_consume(bus.instr_ready, bus.stall);

    // A halt consume never counts as a branch even if the mux says taken.
    assign br_inc = consume && !bus.halt && br_taken;

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case can leave one unassigned and infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        imem_req_d    = imem_req_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;

        unique case (state_q)
            ST_RST: begin
                state_d    = ST_REQ;
                imem_req_d = 1'b1;
            end

            ST_REQ: begin
                // Request stays up with a stable address until acked; the
                // drop of imem_req and the rise of instr_valid share an edge.
                if (bus.imem_ack) begin
                    instr_d       = bus.imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (consume) begin
                    instr_valid_d = 1'b0;
                    if (bus.halt) begin
                        // PC is left pointing at the halt instruction.
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else begin
                        pc_d       = next_pc;
                        imem_req_d = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
            end

            ST_HALTED: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end

            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Reset abandons any outstanding request; acks that arrive while
            // in RST are simply not looked at.
            state_q       <= ST_RST;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pc_plus1        = pc_q + PC_W'(1);   // wraps at 2^PC_W, no carry out
    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign halted          = halted_q;

    // -------------------------------------------------------------------------
    // Taken-branch counter
    // -------------------------------------------------------------------------
`ifdef FETCH_BR_COUNT_EN
    sat_counter8 u_br_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_inc),
        .count (br_count)
    );
`else
    logic unused_br_inc;
    assign unused_br_inc = br_inc;
    assign br_count      = 8'h00;
`endif

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    // Never a request while an instruction is still waiting for decode.
    a_req_valid_exclusive: assert property (
        @(posedge clk) rst_n |-> !(imem_req_q && instr_valid_q));

    // A halted unit is completely quiet.
    a_halted_quiet: assert property (
        @(posedge clk) (rst_n && halted_q) |-> (!imem_req_q && !instr_valid_q));

    // An unacked request is held with the same address.
    a_req_stable: assert property (
        @(posedge clk) (rst_n && (state_q == ST_REQ) && !bus.imem_ack)
                       |=> (imem_req_q && $stable(pc_q)));

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Self-checking bench for fetch_pc_unit. Directed scenario tasks cover reset,
// sequential fetch, wait states, branch/wrap, stall priority, halt, reset in
// the middle of a request and branch-counter saturation; a randomized phase
// compares every cycle against a transaction-level model of the fetch unit.
// The expected br_count follows whether FETCH_BR_COUNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    localparam int         PC_W     = 6;
    localparam int         INSTR_W  = 16;
    localparam logic [5:0] RESET_PC = 6'd0;
`ifdef FETCH_BR_COUNT_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  next_pc;
    logic        br_taken;
    logic [5:0]  pc_plus1;
    logic        halted;
    logic [7:0]  br_count;

    int checks   = 0;
    int failures = 0;

    fetch_pc_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_pc_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .next_pc  (next_pc),
        .br_taken (br_taken),
        .pc_plus1 (pc_plus1),
        .halted   (halted),
        .br_count (br_count),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model: what the unit is doing, in transaction terms.
    //   m_restart : one dead cycle owed after reset before the first request
    //   m_req     : a fetch of m_pc is outstanding
    //   m_valid   : an instruction is waiting for decode
    //   m_halted  : a halt was consumed
    // -------------------------------------------------------------------------
    logic [5:0]  m_pc;
    logic [5:0]  m_ipc;
    logic [15:0] m_instr;
    logic        m_req, m_valid, m_halted, m_restart;
    int          m_br;

    function automatic void model_step();
        if (!rst_n) begin
            m_pc = RESET_PC; m_ipc = '0; m_instr = '0;
            m_req = 1'b0; m_valid = 1'b0; m_halted = 1'b0; m_restart = 1'b1;
            m_br = 0;
        end else if (m_restart) begin
            m_restart = 1'b0;
            m_req     = 1'b1;
        end else if (m_halted) begin
            // parked until reset
        end else if (m_req) begin
            if (bus.imem_ack) begin
                m_instr = bus.imem_rdata;
                m_ipc   = m_pc;
                m_valid = 1'b1;
                m_req   = 1'b0;
            end
        end else if (m_valid && bus.instr_ready && !bus.stall) begin
            m_valid = 1'b0;
            if (bus.halt) begin
                m_halted = 1'b1;
            end else begin
                m_pc  = next_pc;
                m_req = 1'b1;
                if (BR_EN && br_taken && m_br < 255) m_br++;
            end
        end
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus helpers (no checking apart from a bounded wait)
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.stall       = 1'b0;
        bus.halt        = 1'b0;
        br_taken        = 1'b0;
        next_pc         = '0;
    endtask

    // Serve the outstanding request after 'waits' idle cycles, returning
    // 16'h1000 + address.
    task automatic fetch(input int waits);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL fetch_timeout: imem_req=%b required 1 within 8 cycles", bus.imem_req);
        end
        for (int i = 0; i < waits; i++) tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h1000 + 16'(bus.imem_addr);
        tick();
        bus.imem_ack   = 1'b0;
    endtask

    task automatic consume(input logic [5:0] npc, input logic br, input logic hlt);
        bus.instr_ready = 1'b1;
        bus.stall       = 1'b0;
        bus.halt        = hlt;
        br_taken        = br;
        next_pc         = npc;
        tick();
        bus.instr_ready = 1'b0;
        bus.halt        = 1'b0;
        br_taken        = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        checks++;
        if ({bus.imem_req, bus.instr_valid, halted} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: req/valid/halted=%b required 000",
                     {bus.imem_req, bus.instr_valid, halted});
        end
        checks++;
        if (bus.imem_addr !== RESET_PC || bus.instr !== 16'h0000 || bus.instr_pc !== 6'h00) begin
            failures++;
            $display("FAIL reset_regs: addr=%h instr=%h instr_pc=%h required %h 0000 00",
                     bus.imem_addr, bus.instr, bus.instr_pc, RESET_PC);
        end
        checks++;
        if (br_count !== 8'h00 || pc_plus1 !== 6'd1) begin
            failures++;
            $display("FAIL reset_misc: br_count=%h pc_plus1=%h required 00 01", br_count, pc_plus1);
        end
    endtask

    task automatic test_seq_fetch();
        int k = 0;
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL req_rise: req=%b valid=%b required 1 0", bus.imem_req, bus.instr_valid);
        end
        for (int i = 0; i < 6; i++) begin
            bus.imem_ack   = bus.imem_req;
            bus.imem_rdata = 16'h1000 + 16'(bus.imem_addr);
            next_pc        = pc_plus1;
            tick();
            checks++;
            if (bus.instr_valid !== logic'(i % 2 == 0)) begin
                failures++;
                $display("FAIL seq_valid[%0d]: valid=%b required %b", i, bus.instr_valid, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                checks++;
                if (bus.instr !== 16'(16'h1000 + k) || bus.instr_pc !== 6'(k)) begin
                    failures++;
                    $display("FAIL seq_instr[%0d]: instr=%h pc=%h required %h %h",
                             k, bus.instr, bus.instr_pc, 16'(16'h1000 + k), 6'(k));
                end
                k++;
            end
        end
        idle();
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 6'd3 || bus.instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold[%0d]: req=%b addr=%h valid=%b required 1 03 0",
                         i, bus.imem_req, bus.imem_addr, bus.instr_valid);
            end
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h1003;
        tick();
        bus.imem_ack   = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 ||
            bus.instr !== 16'h1003 || bus.instr_pc !== 6'd3) begin
            failures++;
            $display("FAIL wait_ack: valid=%b req=%b instr=%h pc=%h required 1 0 1003 03",
                     bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_branch_wrap();
        logic [7:0] exp_br;
        consume(6'd4, 1'b0, 1'b0);
        fetch(0);
        consume(6'd5, 1'b0, 1'b0);
        fetch(0);
        checks++;
        if (bus.instr_pc !== 6'd5) begin
            failures++;
            $display("FAIL br_setup: instr_pc=%h required 05", bus.instr_pc);
        end
        consume(6'h3F, 1'b1, 1'b0);
        checks++;
        if (bus.imem_addr !== 6'h3F || pc_plus1 !== 6'h00 || bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL br_target: addr=%h pc_plus1=%h req=%b required 3f 00 1",
                     bus.imem_addr, pc_plus1, bus.imem_req);
        end
        fetch(1);
        checks++;
        if (bus.instr_pc !== 6'h3F || bus.instr !== 16'h103F) begin
            failures++;
            $display("FAIL br_fetch: pc=%h instr=%h required 3f 103f", bus.instr_pc, bus.instr);
        end
        consume(6'((63 + 1) % 64), 1'b0, 1'b0);
        checks++;
        if (bus.imem_addr !== 6'h00) begin
            failures++;
            $display("FAIL wrap_addr: addr=%h required 00", bus.imem_addr);
        end
        exp_br = BR_EN ? 8'd1 : 8'd0;
        checks++;
        if (br_count !== exp_br) begin
            failures++;
            $display("FAIL br_count_one: br_count=%h required %h", br_count, exp_br);
        end
    endtask

    task automatic test_stall();
        fetch(0);
        for (int i = 0; i < 6; i++) begin
            // 4 cycles stall+ready (halt joins for the last two), then 2
            // cycles halt without ready.
            bus.stall       = (i < 4);
            bus.instr_ready = (i < 4);
            bus.halt        = (i >= 2);
            next_pc         = 6'h2A;
            tick();
            checks++;
            if (bus.instr !== 16'h1000 || bus.instr_pc !== 6'h00 || bus.imem_addr !== 6'h00 ||
                bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || halted !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: instr=%h pc=%h addr=%h valid=%b req=%b halted=%b required 1000 00 00 1 0 0",
                         i, bus.instr, bus.instr_pc, bus.imem_addr, bus.instr_valid, bus.imem_req, halted);
            end
        end
        bus.halt = 1'b0;
        bus.stall = 1'b0;
        bus.instr_ready = 1'b1;
        next_pc = 6'h2A;
        tick();
        idle();
        checks++;
        if (bus.imem_addr !== 6'h2A || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: addr=%h valid=%b req=%b required 2a 0 1",
                     bus.imem_addr, bus.instr_valid, bus.imem_req);
        end
    endtask

    task automatic test_halt();
        logic [7:0] exp_br;
        exp_br = BR_EN ? 8'd1 : 8'd0;
        fetch(0);
        consume(6'd7, 1'b0, 1'b0);
        fetch(2);
        consume(6'h11, 1'b1, 1'b1);
        checks++;
        if (halted !== 1'b1 || bus.imem_addr !== 6'd7 || bus.imem_req !== 1'b0 ||
            bus.instr_valid !== 1'b0 || br_count !== exp_br) begin
            failures++;
            $display("FAIL halt_enter: halted=%b addr=%h req=%b valid=%b br=%h required 1 07 0 0 %h",
                     halted, bus.imem_addr, bus.imem_req, bus.instr_valid, br_count, exp_br);
        end
        for (int i = 0; i < 6; i++) begin
            bus.instr_ready = 1'($urandom_range(0, 1));
            bus.stall       = 1'($urandom_range(0, 1));
            bus.imem_ack    = 1'b1;
            bus.imem_rdata  = 16'($urandom);
            next_pc         = 6'($urandom);
            br_taken        = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (halted !== 1'b1 || bus.imem_addr !== 6'd7 || bus.imem_req !== 1'b0 ||
                bus.instr_valid !== 1'b0 || bus.instr !== 16'h1007 || bus.instr_pc !== 6'd7) begin
                failures++;
                $display("FAIL halt_parked[%0d]: halted=%b addr=%h req=%b valid=%b instr=%h pc=%h required 1 07 0 0 1007 07",
                         i, halted, bus.imem_addr, bus.imem_req, bus.instr_valid, bus.instr, bus.instr_pc);
            end
        end
        idle();
        rst_n = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b0 || bus.imem_addr !== RESET_PC || bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset: halted=%b addr=%h req=%b required 0 %h 0",
                     halted, bus.imem_addr, bus.imem_req, RESET_PC);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL halt_restart: req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_reset_mid_req();
        fetch(0);
        consume(6'd9, 1'b0, 1'b0);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 6'd9) begin
            failures++;
            $display("FAIL midreq_setup: req=%b addr=%h required 1 09", bus.imem_req, bus.imem_addr);
        end
        rst_n          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hBEEF;
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 ||
            bus.imem_addr !== RESET_PC || bus.instr !== 16'h0000) begin
            failures++;
            $display("FAIL midreq_reset: valid=%b req=%b addr=%h instr=%h required 0 0 %h 0000",
                     bus.instr_valid, bus.imem_req, bus.imem_addr, bus.instr, RESET_PC);
        end
        rst_n = 1'b1;   // ack still high: must be ignored in the dead cycle
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
            bus.imem_addr !== RESET_PC || bus.instr !== 16'h0000) begin
            failures++;
            $display("FAIL midreq_ignore: valid=%b req=%b addr=%h instr=%h required 0 1 %h 0000",
                     bus.instr_valid, bus.imem_req, bus.imem_addr, bus.instr, RESET_PC);
        end
        bus.imem_rdata = 16'h1000;
        tick();
        bus.imem_ack = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== RESET_PC || bus.instr !== 16'h1000) begin
            failures++;
            $display("FAIL midreq_refetch: valid=%b pc=%h instr=%h required 1 %h 1000",
                     bus.instr_valid, bus.instr_pc, bus.instr, RESET_PC);
        end
        consume(6'd1, 1'b0, 1'b0);
    endtask

    task automatic test_br_saturate();
        logic [7:0] exp_br;
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            fetch(0);
            consume(6'($urandom), 1'b1, 1'b0);
            if (i == 199) begin
                exp_br = BR_EN ? 8'd200 : 8'd0;
                checks++;
                if (br_count !== exp_br) begin
                    failures++;
                    $display("FAIL br_count_200: br_count=%h required %h", br_count, exp_br);
                end
            end
        end
        exp_br = BR_EN ? 8'hFF : 8'h00;
        checks++;
        if (br_count !== exp_br) begin
            failures++;
            $display("FAIL br_count_sat: br_count=%h required %h", br_count, exp_br);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_n           = ($urandom_range(0, 49) != 0);
            bus.imem_ack    = 1'($urandom_range(0, 1));
            bus.imem_rdata  = 16'($urandom);
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.halt        = ($urandom_range(0, 31) == 0);
            br_taken        = 1'($urandom_range(0, 1));
            next_pc         = br_taken ? 6'($urandom) : 6'((m_pc + 1) % 64);
            tick();
            checks++;
            if ({bus.imem_req, bus.instr_valid, halted, bus.imem_addr, bus.instr_pc,
                 bus.instr, br_count, pc_plus1} !==
                {m_req, m_valid, m_halted, m_pc, m_ipc, m_instr, 8'(m_br), 6'((m_pc + 1) % 64)}) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random[%0d]: req=%b valid=%b halted=%b addr=%h ipc=%h instr=%h br=%h p1=%h required %b %b %b %h %h %h %h %h",
                             i, bus.imem_req, bus.instr_valid, halted, bus.imem_addr, bus.instr_pc,
                             bus.instr, br_count, pc_plus1, m_req, m_valid, m_halted, m_pc, m_ipc,
                             m_instr, 8'(m_br), 6'((m_pc + 1) % 64));
                bad++;
            end
        end
        idle();
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Sequence
    // -------------------------------------------------------------------------
    initial begin
        m_restart = 1'b0;
        idle();
        test_reset();
        test_seq_fetch();
        test_wait_states();
        test_branch_wrap();
        test_stall();
        test_halt();
        test_reset_mid_req();
        test_br_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-stage program counter and instruction-fetch sequencer for the 16-bit single-cycle core. Holds the 6-bit PC, exports PC+1 to the branch-select mux, and loads the mux's selected next PC once the current instruction is consumed. Fetches 16-bit instructions from instruction memory through a req/ack handshake and presents them to decode through a valid/ready handshake.

## Interface
Parameters:
- PC_W, 6, program counter / instruction address width
- INSTR_W, 16, instruction width
- RESET_PC, 6'd0, PC value loaded on reset

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- next_pc  in  PC_W  selected next PC from the branch-select mux
- br_taken  in  1  branch-select of that mux (1 = branch target chosen)
- pc_plus1  out  PC_W  pc + 1 modulo 2^PC_W, combinational; feeds the mux's sequential input
- imem_req  out  1  fetch request, registered
- imem_addr  out  PC_W  fetch address, equals pc
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  INSTR_W  fetched instruction
- instr  out  INSTR_W  instruction to decode, registered
- instr_pc  out  PC_W  address of instr
- instr_valid  out  1  instr holds an unconsumed instruction
- instr_ready  in  1  decode accepts instr
- stall  in  1  hazard hold; overrides instr_ready
- halt  in  1  decode flags instr as a halt instruction
- halted  out  1  core halted
- br_count  out  8  taken-branch count (see Configuration)

## Operation
- States: RST, REQ, HOLD, HALTED. Two-bit encoding.
- Reset (rst_n=0 at an edge): pc=RESET_PC, state=RST, imem_req=0, instr=0, instr_pc=0, instr_valid=0, halted=0, br_count=0.
- RST → REQ unconditionally after one cycle.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr←imem_rdata, instr_pc←pc, instr_valid←1, imem_req←0, go HOLD.
  - Without ack: remain in REQ, request held stable.
- HOLD:
  - instr_valid=1. A consume is instr_ready=1 and stall=0.
  - On a consume with halt=0: pc←next_pc, instr_valid←0, go REQ.
  - On a consume with halt=1: pc unchanged, instr_valid←0, halted←1, go HALTED.
  - Without a consume, all registers hold.
- HALTED: imem_req=0 and instr_valid=0. The unit leaves HALTED only on reset.
- Arithmetic: pc_plus1 wraps, so 6'd63+1=6'd0. No overflow flag.
- imem_ack outside REQ is ignored. imem_rdata is sampled only with ack in REQ.
- br_taken is sampled only on a consume. It does not affect the pc path; the mux has already resolved next_pc.

## Timing
- Fetch latency: imem_req rises 1 cycle after reset release. instr_valid rises at the edge of the ack cycle.
- Throughput with zero-wait memory and an always-ready decode: one instruction per 2 cycles (REQ, HOLD).
- imem_req falls at the same edge at which instr_valid rises. No back-to-back requests.
- Stall and ready asserted together: stall wins, nothing changes.
- Halt without ready, or halt with stall: no effect.
- Reset mid-REQ: an outstanding request is abandoned. imem_req=0 after that edge, and any ack in the following cycles is ignored until REQ is re-entered.

## Configuration
- FETCH_BR_COUNT_EN defined: br_count is an 8-bit saturating counter.
  - It increments on each consume with br_taken=1 and halt=0.
  - It holds at 8'hFF and clears only on reset.
- FETCH_BR_COUNT_EN undefined: br_count is tied to 8'h00 and no counter logic is built. The port is always present.

## Structure
- Shared package fetch_pkg holds:
  - PC_W, INSTR_W, RESET_PC defaults
  - state encoding constants: ST_RST=2'b00, ST_REQ=2'b01, ST_HOLD=2'b10, ST_HALTED=2'b11
- One sub-module, sat_counter8: an 8-bit saturating counter with inc, clk, rst_n. It is instantiated only under FETCH_BR_COUNT_EN.

## Test plan
- Reset and zero-wait sequential fetch:
  - Stimulus: hold rst_n=0 for 2 cycles, then release; ack each request with rdata=16'h1000+addr; instr_ready=1; next_pc=pc_plus1.
  - Response: all outputs 0 during reset; instr_pc sequence 0,1,2 with instr 16'h1000,16'h1001,16'h1002; instr_valid every other cycle.
- Wait states: ack 3 cycles after imem_req.
  - Response: imem_req held high with a stable imem_addr for 3 cycles; instr_valid rises at the edge of the ack cycle.
- Branch and wrap:
  - At instr_pc=5, drive br_taken=1 with next_pc=6'h3F → next imem_addr=6'h3F, pc_plus1=6'h00.
  - The following sequential consume gives imem_addr=6'h00.
  - With FETCH_BR_COUNT_EN, br_count=1.
- Stall priority: stall=1 and instr_ready=1 for 4 cycles in HOLD.
  - Response: instr, instr_pc and pc unchanged; instr_valid stays 1.
  - Release stall → pc←next_pc on the next edge.
- Halt:
  - Consume with halt=1 at instr_pc=7 → halted=1, pc=7, imem_req=0.
  - Further ready/ack activity causes no change.
  - Reset restores pc=RESET_PC and halted=0.
- Reset mid-request: assert rst_n=0 while in REQ, with ack arriving in that same cycle.
  - Response: instr_valid stays 0, pc=RESET_PC.
  - Fetch restarts from RESET_PC after release.
